// File: rtl/smart_home_pkg.sv
// Shared constants, state encoding and status word layout for the status transmitter.
package smart_home_pkg;

    localparam int unsigned STATUS_W   = 12;
    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned CYC_CNT_W  = 8;

    // Field offsets and widths inside the status word D
    localparam int unsigned HEAT_OFS   = 0;
    localparam int unsigned COOL_OFS   = 1;
    localparam int unsigned BLINDS_OFS = 2;
    localparam int unsigned COLOUR_OFS = 4;
    localparam int unsigned TEMP_OFS   = 7;
    localparam int unsigned BLINDS_W   = 2;
    localparam int unsigned COLOUR_W   = 3;
    localparam int unsigned TEMP_W     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Even parity over the status word
    function automatic logic even_parity(input logic [STATUS_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit tick generator: pulses tick_c every CLKS_PER_BIT cycles while run is high.
module bit_timer
    import smart_home_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic tick_c
);

    localparam logic [CYC_CNT_W-1:0] LAST = CYC_CNT_W'(CLKS_PER_BIT - 1);

    logic [CYC_CNT_W-1:0] cnt_q;
    logic [CYC_CNT_W-1:0] cnt_d;

    assign tick_c = run && (cnt_q == LAST);

    // Cycle counter: cleared on frame acceptance, wraps at the end of each bit
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick_c ? '0 : cnt_q + CYC_CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/status_tx.sv
// Serial status frame transmitter: start, 12 data bits LSB-first, optional parity, stop.
// Optional feature: define STATUS_TX_PARITY_EN to insert an even parity bit after the data.
module status_tx
    import smart_home_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heating,
    input  logic       cooling,
    input  logic [1:0] blinds,
    input  logic [2:0] colour,
    input  logic [4:0] temperature,
    input  logic       send_req,
    output logic       ready,
    output logic       tx,
    output logic       done
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(STATUS_W - 1);

    state_t                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [STATUS_W-1:0]   snap_q, snap_d;
    logic                  tx_q, tx_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  accept_c;
    logic                  tick_c;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (accept_c),
        .run     (state_q != ST_IDLE),
        .tick_c  (tick_c)
    );

    // Next-state, next-bit and registered-output logic
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        snap_d   = snap_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        accept_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (send_req) begin
                    accept_c = 1'b1;
                    snap_d[HEAT_OFS]                 = heating;
                    snap_d[COOL_OFS]                 = cooling;
                    snap_d[BLINDS_OFS +: BLINDS_W]   = blinds;
                    snap_d[COLOUR_OFS +: COLOUR_W]   = colour;
                    snap_d[TEMP_OFS +: TEMP_W]       = temperature;
                    state_d  = ST_START;
                    bit_d    = '0;
                    tx_d     = 1'b0;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = snap_q[0];
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef STATUS_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = even_parity(snap_q);
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                        tx_d  = snap_q[bit_q + BIT_CNT_W'(1)];
                    end
                end
            end
            ST_PARITY: begin
                if (tick_c) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            snap_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_status_tx.sv
// Directed testbench for status_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_status_tx;

    logic       clk = 1'b0;
    logic       rst4, rst1;
    logic       req4, req1;
    logic       heating, cooling;
    logic [1:0] blinds;
    logic [2:0] colour;
    logic [4:0] temperature;
    logic       ready4, tx4, done4;
    logic       ready1, tx1, done1;
    logic       sel;
    logic       obs_tx, obs_ready, obs_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    status_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst4), .heating(heating), .cooling(cooling), .blinds(blinds),
        .colour(colour), .temperature(temperature), .send_req(req4),
        .ready(ready4), .tx(tx4), .done(done4)
    );

    status_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst1), .heating(heating), .cooling(cooling), .blinds(blinds),
        .colour(colour), .temperature(temperature), .send_req(req1),
        .ready(ready1), .tx(tx1), .done(done1)
    );

    assign obs_tx    = sel ? tx1    : tx4;
    assign obs_ready = sel ? ready1 : ready4;
    assign obs_done  = sel ? done1  : done4;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the data inputs from a 12-bit word {temperature, colour, blinds, cooling, heating}
    task automatic set_inputs(input logic [11:0] d);
        heating     = d[0];
        cooling     = d[1];
        blinds      = d[3:2];
        colour      = d[6:4];
        temperature = d[11:7];
    endtask

    task automatic drive_req(input logic s, input logic v);
        if (s) req1 = v;
        else   req4 = v;
    endtask

    // Caller has set the request high; the next edge accepts it.
    // mode 0: drop request; 1: hold request; 2: drop, then pulse once mid-frame.
    task automatic check_frame(input logic s, input int n, input logic [11:0] d,
                               input logic [11:0] nxt, input int mode, input string name);
        logic [14:0] fb;
        int nb;
        int k;
        fb = '1;
        fb[0] = 1'b0;
        fb[12:1] = d;
`ifdef STATUS_TX_PARITY_EN
        fb[13] = ^d;
        nb = 15;
`else
        nb = 14;
`endif
        sel = s;
        tick();
        set_inputs(nxt);
        if (mode != 1) drive_req(s, 1'b0);
        k = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < n; c++) begin
                if (mode == 2) drive_req(s, k == 20);
                checks++;
                if (obs_tx !== fb[b])
                    $display("FAIL %s tx bit %0d cycle %0d: got %b want %b", name, b, c, obs_tx, fb[b]);
                if (obs_tx !== fb[b]) errors++;
                checks++;
                if (obs_done !== 1'b0 || obs_ready !== 1'b0) begin
                    $display("FAIL %s busy flags bit %0d: done=%b ready=%b want 0/0", name, b, obs_done, obs_ready);
                    errors++;
                end
                tick();
                k++;
            end
        end
        checks++;
        if (obs_done !== 1'b1 || obs_ready !== 1'b1 || obs_tx !== 1'b1) begin
            $display("FAIL %s end: done=%b ready=%b tx=%b want 1/1/1", name, obs_done, obs_ready, obs_tx);
            errors++;
        end
    endtask

    task automatic check_idle(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            checks++;
            if (obs_tx !== 1'b1 || obs_ready !== 1'b1 || obs_done !== 1'b0) begin
                $display("FAIL %s cycle %0d: tx=%b ready=%b done=%b want 1/1/0", name, i, obs_tx, obs_ready, obs_done);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst1 = 1'b1; req4 = 1'b0; req1 = 1'b0; sel = 1'b0;
        set_inputs(12'h000);
        tick(); tick();
        rst4 = 1'b0; rst1 = 1'b0;
        sel = 1'b0;
        check_idle(10, "reset_idle_n4");
        sel = 1'b1;
        check_idle(10, "reset_idle_n1");
        sel = 1'b0;
    endtask

    task automatic test_frame();
        set_inputs(12'hAD9);
        req4 = 1'b1;
        check_frame(1'b0, 4, 12'hAD9, 12'h526, 0, "frame_ad9");
        tick();
        check_idle(6, "after_frame");
    endtask

    task automatic test_busy_ignored();
        set_inputs(12'h35C);
        req4 = 1'b1;
        check_frame(1'b0, 4, 12'h35C, 12'hFFF, 2, "busy_pulse");
        tick();
        check_idle(8, "busy_not_queued");
    endtask

    task automatic test_back_to_back();
        set_inputs(12'h123);
        req4 = 1'b1;
        check_frame(1'b0, 4, 12'h123, 12'hE4B, 1, "b2b_first");
        check_frame(1'b0, 4, 12'hE4B, 12'h000, 1, "b2b_second");
        check_frame(1'b0, 4, 12'h000, 12'h000, 0, "b2b_third");
        tick();
        check_idle(5, "b2b_single_done");
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] d;
        d = 12'hAD9;
        set_inputs(d);
        req4 = 1'b1;
        tick();
        req4 = 1'b0;
        repeat (25) tick();
        checks++;
        if (tx4 !== d[5]) begin
            $display("FAIL mid_frame_bit5: got %b want %b", tx4, d[5]);
            errors++;
        end
        rst4 = 1'b1;
        req4 = 1'b1;
        tick();
        checks++;
        if (tx4 !== 1'b1 || ready4 !== 1'b1 || done4 !== 1'b0) begin
            $display("FAIL rst_abort: tx=%b ready=%b done=%b want 1/1/0", tx4, ready4, done4);
            errors++;
        end
        rst4 = 1'b0;
        req4 = 1'b0;
        tick();
        check_idle(6, "rst_no_done");
        req4 = 1'b1;
        check_frame(1'b0, 4, d, 12'h000, 0, "frame_after_rst");
        tick();
    endtask

    task automatic test_one_clk_per_bit();
        set_inputs(12'hF80);
        req1 = 1'b1;
        check_frame(1'b1, 1, 12'hF80, 12'h07F, 0, "n1_temp31");
        tick();
        check_idle(4, "n1_after");
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_one_clk_per_bit();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_tx.md
STATUS_TX -- requirements
Module: status_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 1..255).
REQ-002 clk  input  1  single clock; all logic updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 heating  input  1  heater-on status to report.
REQ-005 cooling  input  1  cooler-on status to report.
REQ-006 blinds  input  2  blinds position code to report.
REQ-007 colour  input  3  light colour code to report.
REQ-008 temperature  input  5  current temperature reading to report.
REQ-009 send_req  input  1  request to transmit one status frame.
REQ-010 ready  output  1  high when a request can be accepted this cycle.
REQ-011 tx  output  1  serial line; idle level 1.
REQ-012 done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-013 Accept a request on the rising edge where send_req=1 and ready=1; ready SHALL be 1 only in IDLE.
REQ-014 On acceptance, snapshot data word D[11:0] = {temperature, colour, blinds, cooling, heating}; input changes after acceptance SHALL NOT affect the frame.
REQ-015 FSM states IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE; each non-IDLE state SHALL last CLKS_PER_BIT cycles per bit.
REQ-016 tx is registered: 1 in IDLE/STOP, 0 in START, D[i] LSB-first in DATA (12 bits), parity bit in PARITY.
REQ-017 START begins on the cycle after acceptance; the bit counter wraps 11 -> exit DATA, never beyond.
REQ-018 At STOP completion the FSM returns to IDLE, and done=1 for exactly that first IDLE cycle.
REQ-019 A request in the done cycle SHALL be accepted, giving back-to-back frames with no idle bit between them.
REQ-020 send_req while busy SHALL be ignored, not queued.
REQ-021 CLKS_PER_BIT=1 SHALL produce one bit per cycle with identical framing.

Reset
REQ-022 While rst=1 at a clock edge: state=IDLE, tx=1, ready=1, done=0, bit and cycle counters=0, snapshot=0.
REQ-023 rst mid-frame SHALL abort the frame; tx=1 from the next edge, with no done pulse.
REQ-024 rst takes priority over a simultaneous send_req.

Configuration
REQ-025 Macro STATUS_TX_PARITY_EN defined: PARITY state inserted after DATA, bit = even parity (XOR of D[11:0]); frame = 15 bits.
REQ-026 Macro STATUS_TX_PARITY_EN undefined: no PARITY state, DATA proceeds directly to STOP; frame = 14 bits.

Structure
REQ-027 Package smart_home_pkg SHALL hold the STATUS_W=12 constant, the state enumeration, and the field offsets of D.
REQ-028 One sub-module, bit_timer, SHALL generate the per-bit tick from CLKS_PER_BIT, restarting on frame acceptance.

Verification
REQ-029 After reset with CLKS_PER_BIT=4: tx=1, ready=1, done=0 for 10 cycles with send_req=0.
REQ-030 heating=1, cooling=0, blinds=2'b10, colour=3'b101, temperature=21, send_req pulsed -> D=0xAD9; tx bits 0,1,0,0,1,1,0,1,1,0,1,0,1,1 (no parity), 4 cycles each; done 56 cycles after the start bit begins.
REQ-031 Same stimulus with STATUS_TX_PARITY_EN -> parity bit 1 before stop; frame 60 cycles.
REQ-032 send_req held high -> consecutive frames; start bit immediately follows stop; one done per frame; inputs changed mid-frame appear only in the next frame.
REQ-033 rst asserted in DATA bit 5 -> tx=1 next cycle, no done, ready=1; next request sends a complete, correct frame.
REQ-034 CLKS_PER_BIT=1 with temperature=31 and all other inputs 0 -> 14-cycle frame; data bits 0,0,0,0,0,0,0,1,1,1,1,1.
